// File: rtl/seg_scan_display.sv
// Time-multiplexed DIGITS-wide hex seven-segment driver with frame-aligned value commit.
// Optional leading-zero blanking: define SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_display #(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4*DIGITS-1:0]   DATA,
  input  logic [DIGITS-1:0]     DP_IN,
  input  logic                  LOAD,
  output logic                  PENDING,
  output logic                  FRAME,
  output logic [DIGITS-1:0]     AN,
  output logic [6:0]            HEX,
  output logic                  DP
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DW    = 4 * DIGITS;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0]  div_q, div_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DW-1:0]     pend_data_q, pend_data_d, disp_data_q, disp_data_d;
  logic [DIGITS-1:0] pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic              pend_v_q, pend_v_d;
  logic              frame_q, frame_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        hex_q, hex_d;
  logic              dp_q, dp_d;
  logic              div_wrap, commit, blank;
  logic [3:0]        nib;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // Scan counters, frame-boundary commit and next-cycle output image
  always_comb begin
    div_d       = div_q;
    idx_d       = idx_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    disp_data_d = disp_data_q;
    disp_dp_d   = disp_dp_q;
    pend_v_d    = pend_v_q;
    an_d        = '1;
    hex_d       = 7'h7F;
    dp_d        = 1'b1;
    blank       = 1'b0;

    div_wrap = (div_q == DIV_LAST);
    commit   = div_wrap && (idx_q == IDX_LAST);

    div_d = div_wrap ? '0 : div_q + DIV_W'(1);
    if (div_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    // A load landing on the commit cycle bypasses the pending stage
    if (commit) begin
      pend_v_d = 1'b0;
      if (LOAD) begin
        disp_data_d = DATA;
        disp_dp_d   = DP_IN;
      end else if (pend_v_q) begin
        disp_data_d = pend_data_q;
        disp_dp_d   = pend_dp_q;
      end
    end else if (LOAD) begin
      pend_data_d = DATA;
      pend_dp_d   = DP_IN;
      pend_v_d    = 1'b1;
    end

    frame_d = (div_d == DIV_LAST) && (idx_d == IDX_LAST);

`ifdef SEG_LEADING_ZERO_BLANK_EN
    blank = (idx_d != '0)
         && ((disp_data_d >> (32'(idx_d) * 32'd4)) == '0)
         && ((disp_dp_d >> idx_d) == '0);
`endif

    nib = 4'(disp_data_d >> (32'(idx_d) * 32'd4));
    // First cycle of every slot stays dark to avoid ghosting between digits
    if ((div_d != '0) && !blank) begin
      an_d  = ~(DIGITS'(1) << idx_d);
      hex_d = hex7(nib);
      dp_d  = ~(1'(disp_dp_d >> idx_d));
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q       <= '0;
      idx_q       <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      disp_data_q <= '0;
      disp_dp_q   <= '0;
      pend_v_q    <= 1'b0;
      frame_q     <= 1'b0;
      an_q        <= '1;
      hex_q       <= 7'h7F;
      dp_q        <= 1'b1;
    end else begin
      div_q       <= div_d;
      idx_q       <= idx_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      disp_data_q <= disp_data_d;
      disp_dp_q   <= disp_dp_d;
      pend_v_q    <= pend_v_d;
      frame_q     <= frame_d;
      an_q        <= an_d;
      hex_q       <= hex_d;
      dp_q        <= dp_d;
    end
  end

  assign PENDING = pend_v_q;
  assign FRAME   = frame_q;
  assign AN      = an_q;
  assign HEX     = hex_q;
  assign DP      = dp_q;

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Parametrised, time-multiplexed seven-segment display driver: the next generation of the single-digit, mode-selected switch display, extended to show a full multi-digit hex value. Holds a DIGITS-nibble display value, scans digits one at a time on the board's active-low anodes, and decodes hex internally. New values are loaded through a one-cycle strobe and committed only at frame boundaries, so a frame never shows a mix of old and new digits. Sits between the top-level datapath and the board pins AN/HEX/DP.

## Interface
- DIGITS, 8: number of digits scanned, 1..8.
- SCAN_DIV, 100000: clock cycles per digit slot, ≥ 2.

- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- DATA  in  4*DIGITS  value to display; nibble k is digit k; digit 0 is rightmost.
- DP_IN  in  DIGITS  decimal point request per digit, 1 = lit.
- LOAD  in  1  one-cycle strobe; captures DATA and DP_IN.
- PENDING  out  1  captured value not yet committed to display.
- FRAME  out  1  one-cycle pulse on every digit-index wrap.
- AN  out  DIGITS  anodes, active-low, at most one low.
- HEX  out  7  segments a..g on bits 0..6, active-low.
- DP  out  1  decimal point, active-low.

## Operation
- State: prescaler `div` (0..SCAN_DIV-1), digit index `idx` (0..DIGITS-1), pending regs `pend_d`/`pend_p`, display regs `disp_d`/`disp_p`, flag `pend_v`.
- `div` increments every cycle and wraps at SCAN_DIV-1. On wrap, `idx` increments and wraps from DIGITS-1 to 0.
- Commit point: the cycle where `idx` wraps to 0. On that cycle:
  - FRAME = 1.
  - If `pend_v` is set, `disp` ← `pend` and `pend_v` ← 0.
- LOAD on a non-commit cycle: `pend` ← DATA/DP_IN and `pend_v` ← 1. A later LOAD before commit overwrites; last one wins.
- LOAD on the commit cycle: DATA/DP_IN go straight to `disp`, and `pend_v` ← 0. This takes priority over the old pending value.
- PENDING = `pend_v`.
- Decode (active-low, a = bit0):
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E
- Anti-ghosting: during the first cycle of each slot (`div` = 0), AN is all ones, HEX = 7F and DP = 1. During the rest of the slot, AN bit `idx` = 0 and the selected digit's segments and DP_IN are driven.
- RST mid-operation: all state and outputs return to reset values on the next edge. Any pending value is discarded.

## Timing
- Reset values: `div` = 0, `idx` = 0, `disp` = 0, `pend` = 0, `pend_v` = 0. Outputs: AN all ones, HEX = 7F, DP = 1, FRAME = 0, PENDING = 0.
- All outputs are registered with one cycle of latency from internal state.
- Slot length is exactly SCAN_DIV cycles; frame length is DIGITS*SCAN_DIV cycles.
- LOAD → PENDING high on the next cycle.
- Committed value appears on AN/HEX at `div` = 1 of digit 0 in the following frame.
- Worst-case LOAD-to-display latency is DIGITS*SCAN_DIV + 1 cycles.
- DIGITS = 1: `idx` is constant 0 and every prescaler wrap is a commit point.

## Configuration
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined: digit k > 0 is blanked when `disp_d` nibbles k..DIGITS-1 are all zero and `disp_p` bits k..DIGITS-1 are all zero. A blanked digit's slot keeps AN all ones, HEX = 7F and DP = 1. Digit 0 is never blanked. Slot timing is unchanged.
- Undefined: every digit is always shown, leading zeros included.

## Test plan
- DIGITS = 4, SCAN_DIV = 4, release reset:
  - AN sequence per slot is F, E, E, E; then F, D, D, D; then F, B, B, B; then F, 7, 7, 7; repeating.
  - HEX = 40 in all active cycles.
  - FRAME pulses every 16 cycles.
- LOAD DATA = 16'h1A3F mid-frame:
  - PENDING goes high the next cycle.
  - Display is unchanged until the wrap.
  - Next frame shows digit0 = 0E, digit1 = 30, digit2 = 08, digit3 = 79.
  - PENDING goes low on the commit cycle.
- Two LOADs in one frame (16'h1111, then 16'h2222): only 2222 is ever displayed.
- LOAD 16'h5555 on the commit cycle while 16'h1111 is pending: 1111 is never shown, 5555 appears in the new frame, and PENDING stays low.
- RST asserted mid-slot with a value pending: the next cycle shows all reset output values, and the subsequent frame displays 0000.
- With SEG_LEADING_ZERO_BLANK_EN defined, DATA = 16'h0050, DP_IN = 0: digits 3 and 2 stay dark, digit 1 = 12, digit 0 = 40.
